// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if -- bundle of the instruction-cache, data-cache and
// physical-memory signals seen by the cache arbiter.
//   master : the arbiter side (takes requests, drives pmem strobes and resps)
//   slave  : the environment side (caches plus physical memory)
// LINE_W / ADDR_W must match the parameters of the cache_arbiter instance.
interface cache_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter -- shares one physical-memory port between an instruction
// cache (line reads) and a data cache (line reads and writebacks).
//
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : synchronous active-high reset; also forces every output to 0
//   bus  : cache_arbiter_if.master
//          i_read/i_addr -> i_rdata/i_resp           instruction cache
//          d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp   data cache
//          pmem_read/pmem_write/pmem_addr/pmem_wdata <- pmem_rdata/pmem_resp
//
// Flow: IDLE -> SERVE_I | SERVE_D -> (pmem_resp) -> RELEASE -> IDLE.
// RELEASE gives the finished requester one cycle to drop its request so it
// is not granted a second time.
//
// Build option: define CACHE_ARBITER_RR_EN for round-robin arbitration on
// simultaneous I/D requests; otherwise the data cache always wins.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  cache_arbiter_if.master   bus
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t state_q, state_d;

  logic d_req;
  logic pick_i;

  assign d_req = bus.d_read | bus.d_write;

`ifdef CACHE_ARBITER_RR_EN
  // favor_i_q = 1 when the data cache was granted last, so the instruction
  // cache wins the next collision.
  logic favor_i_q;

  assign pick_i = bus.i_read & (~d_req | favor_i_q);

  always_ff @(posedge clk) begin
    if (rst)
      favor_i_q <= 1'b0;
    else if (state_q == IDLE && state_d == SERVE_I)
      favor_i_q <= 1'b0;
    else if (state_q == IDLE && state_d == SERVE_D)
      favor_i_q <= 1'b1;
  end
`else
  assign pick_i = bus.i_read & ~d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_i)     state_d = SERVE_I;
        else if (d_req) state_d = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        if (bus.pmem_resp) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic              pmem_read_c, pmem_write_c, i_resp_c, d_resp_c;
  logic [ADDR_W-1:0] pmem_addr_c;
  logic [LINE_W-1:0] pmem_wdata_c, i_rdata_c, d_rdata_c;

  // Outputs decode from the registered state only; rst gates them so the
  // bus is quiet in the reset cycle even if a transaction was in flight.
  always_comb begin
    pmem_read_c  = 1'b0;
    pmem_write_c = 1'b0;
    pmem_addr_c  = '0;
    pmem_wdata_c = '0;
    i_resp_c     = 1'b0;
    i_rdata_c    = '0;
    d_resp_c     = 1'b0;
    d_rdata_c    = '0;
    if (!rst) begin
      case (state_q)
        SERVE_I: begin
          pmem_read_c = 1'b1;
          pmem_addr_c = bus.i_addr;
          if (bus.pmem_resp) begin
            i_resp_c  = 1'b1;
            i_rdata_c = bus.pmem_rdata;
          end
        end
        SERVE_D: begin
          // read+write together is a writeback; the read gets a later grant
          pmem_write_c = bus.d_write;
          pmem_read_c  = bus.d_read & ~bus.d_write;
          pmem_addr_c  = bus.d_addr;
          pmem_wdata_c = bus.d_wdata;
          if (bus.pmem_resp) begin
            d_resp_c  = 1'b1;
            d_rdata_c = bus.pmem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read  = pmem_read_c;
  assign bus.pmem_write = pmem_write_c;
  assign bus.pmem_addr  = pmem_addr_c;
  assign bus.pmem_wdata = pmem_wdata_c;
  assign bus.i_resp     = i_resp_c;
  assign bus.i_rdata    = i_rdata_c;
  assign bus.d_resp     = d_resp_c;
  assign bus.d_rdata    = d_rdata_c;

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: a directed vector table, a hand-written
// collision sequence, then randomized traffic against a transaction-level
// reference model. Honours CACHE_ARBITER_RR_EN the same way as the design.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
`ifdef CACHE_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [AW-1:0] IA  = 32'h0000_0060;
  localparam logic [AW-1:0] DA  = 32'h0000_1000;
  localparam logic [LW-1:0] D55 = {32{8'h55}};
  localparam logic [LW-1:0] DAB = {32{8'hAB}};

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_rd, e_wr, e_ir, e_dr,
                            input logic [AW-1:0] e_addr,
                            input logic [LW-1:0] e_wd, e_ird, e_drd);
    chk({tag, " rd/wr/iresp/dresp"},
        {bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}, {e_rd, e_wr, e_ir, e_dr});
    chk({tag, " pmem_addr"},  bus.pmem_addr,  e_addr);
    chk({tag, " pmem_wdata"}, bus.pmem_wdata, e_wd);
    chk({tag, " i_rdata"},    bus.i_rdata,    e_ird);
    chk({tag, " d_rdata"},    bus.d_rdata,    e_drd);
  endtask

  // Drive one cycle of fixed-address stimulus (called at posedge+1).
  task automatic drive(input logic r, ir, dr, dw, pr);
    rst = r;
    bus.i_read = ir; bus.i_addr = IA;
    bus.d_read = dr; bus.d_write = dw; bus.d_addr = DA; bus.d_wdata = D55;
    bus.pmem_resp = pr; bus.pmem_rdata = DAB;
  endtask

  // Check a fixed-address cycle: own 0 = nobody, 1 = I, 2 = D served.
  task automatic expect_own(input string tag, input int own, input logic e_rd, e_wr, e_ir, e_dr);
    check_outs(tag, e_rd, e_wr, e_ir, e_dr,
               (own == 1) ? IA : (own == 2) ? DA : '0,
               (own == 2) ? D55 : '0,
               e_ir ? DAB : '0, e_dr ? DAB : '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, ir, dr, dw, pr;
    int   own;
    logic e_rd, e_wr, e_ir, e_dr;
  } vec_t;

  function automatic vec_t mk(input logic r, ir, dr, dw, pr, input int own,
                              input logic e_rd, e_wr, e_ir, e_dr);
    vec_t v;
    v.r = r; v.ir = ir; v.dr = dr; v.dw = dw; v.pr = pr; v.own = own;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  vec_t tbl[21];

  // random-phase state
  int             m_own, m_lat;
  bit             m_gap, m_fav_i;
  bit             i_pend, d_pend;
  int             d_kind;
  logic [AW-1:0]  ia, da;
  logic [LW-1:0]  dwd, prd;
  logic           pr, rv, e_rd, e_wr, e_ir, e_dr, dq, iq;
  logic [AW-1:0]  e_addr;
  logic [LW-1:0]  e_wd;

  initial begin
    //            rst ir dr dw pr own rd wr ir dr
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); // reset held
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); // cycle after reset, grant latency
    tbl[2]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 1, 1, 1, 0, 1, 0); // third read cycle, i_resp
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // release
    tbl[6]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // stray pmem_resp in idle
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); // writeback request
    tbl[9]  = mk(0, 0, 0, 1, 0, 2, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 1, 2, 0, 1, 0, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0); // read+write together
    tbl[13] = mk(0, 0, 1, 1, 0, 2, 0, 1, 0, 0);
    tbl[14] = mk(0, 0, 1, 1, 1, 2, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); // reset mid SERVE_D
    tbl[19] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0); // late pmem_resp ignored
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    next_cycle();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].r, tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].pr);
      #4;
      expect_own($sformatf("vec%0d", i), tbl[i].own, tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_ir, tbl[i].e_dr);
      next_cycle();
    end

    // Collision sequence; the data cache re-requests immediately to force a
    // second collision. Reset above left the data cache favoured.
    drive(0, 1, 1, 0, 0); #4; expect_own("col idle",  0, 0, 0, 0, 0); next_cycle();
    drive(0, 1, 1, 0, 0); #4; expect_own("col first", 2, 1, 0, 0, 0); next_cycle();
    drive(0, 1, 1, 0, 1); #4; expect_own("col dresp", 2, 1, 0, 0, 1); next_cycle();
    drive(0, 1, 1, 0, 0); #4; expect_own("col rel",   0, 0, 0, 0, 0); next_cycle();
    drive(0, 1, 1, 0, 0); #4; expect_own("col idle2", 0, 0, 0, 0, 0); next_cycle();
    drive(0, 1, 1, 0, 0); #4;
    if (RR) expect_own("col second", 1, 1, 0, 0, 0);
    else    expect_own("col second", 2, 1, 0, 0, 0);
    next_cycle();
    drive(0, 1, 1, 0, 1); #4;
    if (RR) expect_own("col resp2", 1, 1, 0, 1, 0);
    else    expect_own("col resp2", 2, 1, 0, 0, 1);
    next_cycle();
    drive(0, !RR, RR, 0, 0); #4; expect_own("col rel2",  0, 0, 0, 0, 0); next_cycle();
    drive(0, !RR, RR, 0, 0); #4; expect_own("col idle3", 0, 0, 0, 0, 0); next_cycle();
    drive(0, !RR, RR, 0, 0); #4; expect_own("col third", RR ? 2 : 1, 1, 0, 0, 0); next_cycle();
    drive(0, !RR, RR, 0, 1); #4; expect_own("col resp3", RR ? 2 : 1, 1, 0, !RR, RR); next_cycle();
    drive(0, 0, 0, 0, 0);    #4; expect_own("col rel3",  0, 0, 0, 0, 0); next_cycle();

    // Randomized traffic. Model: who owns memory, a one-cycle gap after each
    // completion, and (RR builds) who is owed the next collision.
    drive(1, 0, 0, 0, 0);
    next_cycle();
    m_own = 0; m_gap = 0; m_fav_i = 0; m_lat = 0;
    i_pend = 0; d_pend = 0; d_kind = 0;
    ia = '0; da = '0; dwd = '0;
    for (int c = 0; c < 4000; c++) begin
      rv = ($urandom_range(0, 149) == 0);
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; ia = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_kind = $urandom_range(0, 2); da = $urandom; dwd = rnd_line();
      end
      if (m_own != 0 && !m_gap) pr = (m_lat == 0);
      else                      pr = ($urandom_range(0, 7) == 0);
      prd = rnd_line();

      rst = rv;
      bus.i_read = i_pend; bus.i_addr = ia;
      bus.d_read = d_pend && (d_kind != 1);
      bus.d_write = d_pend && (d_kind != 0);
      bus.d_addr = da; bus.d_wdata = dwd;
      bus.pmem_resp = pr; bus.pmem_rdata = prd;
      #4;

      e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_addr = '0; e_wd = '0;
      if (!rv && !m_gap && m_own == 1) begin
        e_rd = 1; e_addr = ia; e_ir = pr;
      end else if (!rv && !m_gap && m_own == 2) begin
        e_wr = bus.d_write; e_rd = bus.d_read && !bus.d_write;
        e_addr = da; e_wd = dwd; e_dr = pr;
      end
      check_outs($sformatf("rnd%0d", c), e_rd, e_wr, e_ir, e_dr, e_addr, e_wd,
                 e_ir ? prd : '0, e_dr ? prd : '0);

      if (e_ir) i_pend = 0;
      if (e_dr) d_pend = 0;

      dq = bus.d_read || bus.d_write;
      iq = bus.i_read;
      if (rv) begin
        m_own = 0; m_gap = 0; m_fav_i = 0;
      end else if (m_gap) begin
        m_gap = 0;
      end else if (m_own == 0) begin
        if (iq && (!dq || (RR && m_fav_i))) m_own = 1;
        else if (dq)                        m_own = 2;
        if (m_own != 0) begin
          m_lat = $urandom_range(0, 4);
          m_fav_i = (m_own == 2);
        end
      end else if (pr) begin
        m_own = 0; m_gap = 1;
      end else begin
        m_lat--;
      end
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
